alpacacorn_uart_rx: RTL and testbench
=====================================

# alpacacorn_uart_rx

RS232 receive front end for the alpacacorn SoC, placed directly between the `rs232_rx_i` pad and the core's I/O bus.
- Synchronises the asynchronous RX line and deserialises 8N1 frames.
- Buffers received bytes in a small FIFO that the core drains through a valid/ready port.
- Drives hardware flow control on `cts_n_o` from the FIFO fill level.
- Reports framing and overrun errors as sticky flags.

## Interface
- CLKS_PER_BIT, 16, clock cycles per bit; must be even and ≥ 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two ≥ 2.
- CTS_MARGIN, 1, free entries at or below which `cts_n_o` goes high; must satisfy 1 ≤ CTS_MARGIN < FIFO_DEPTH.
- clk_i  in  1  single system clock; all logic is on its rising edge.
- rst_n_i  in  1  reset, synchronous and active-low.
- rs232_rx_i  in  1  asynchronous serial input; idles high.
- rd_data_o  out  8  byte at the FIFO head.
- rd_valid_o  out  1  FIFO is not empty.
- rd_ready_i  in  1  consumer accepts the byte; a pop happens when `rd_valid_o & rd_ready_i`.
- cts_n_o  out  1  flow control, active-low; 0 means the peer may send.
- frame_err_o  out  1  sticky: a stop bit was sampled as 0.
- overrun_o  out  1  sticky: a complete byte arrived while the FIFO was full.
- clr_err_i  in  1  clears both sticky flags.

## Operation
- **Input synchroniser:** two flip-flops on `rs232_rx_i` produce `rx_s`. Both reset to 1.
- **Bit counter:** counts down once per cycle. "Tick" means the counter equals 0.
- **FSM states:**
  - IDLE: when `rx_s`=0, go to START and load the counter with CLKS_PER_BIT/2−1.
  - START: on tick, if `rx_s`=0, go to DATA, load CLKS_PER_BIT−1 and clear the bit index. If `rx_s`=1 on tick, treat it as a glitch and return to IDLE with nothing recorded.
  - DATA: on each tick, shift `rx_s` in LSB-first, reload CLKS_PER_BIT−1 and increment the index. After the 8th sample, go to STOP.
  - STOP: on tick with `rx_s`=1, push the byte and return to IDLE. On tick with `rx_s`=0, set `frame_err_o`, discard the byte and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE.
- **FIFO:**
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
  - A push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A push against a full FIFO with no pop sets `overrun_o` and drops the new byte. Existing entries stay untouched.
  - A pop with the FIFO empty cannot occur, because `rd_valid_o`=0.
  - A simultaneous push and pop leaves the count unchanged.
- **Data output:** `rd_data_o` shows the head entry combinationally from FIFO storage. Its value is don't-care while `rd_valid_o`=0.
- **Flow control:** `cts_n_o` is a register. Each cycle it takes the value (FIFO_DEPTH − next_count ≤ CTS_MARGIN).
  - A frame already in flight is always received.
  - The peer is responsible for stopping within CTS_MARGIN bytes.
- **Sticky flags:** they are cleared by `clr_err_i`. If a set event and `clr_err_i` fall in the same cycle, the set wins and the flag remains 1.
- **Reset:** an active `rst_n_i` aborts any frame in progress. The partially shifted byte is discarded and the FSM returns to IDLE.

## Timing
- **Reset values:** `rd_valid_o`=0, `rd_data_o`=0x00, `cts_n_o`=0, `frame_err_o`=0, `overrun_o`=0. FIFO empty, FSM in IDLE, both synchroniser stages at 1.
- **Synchroniser latency:** 2 cycles from pin to `rx_s`.
- **Sample points:** the start bit is sampled CLKS_PER_BIT/2 cycles after IDLE sees `rx_s`=0. Each data bit and the stop bit follow at CLKS_PER_BIT intervals, so every sample lands mid-bit.
- **Push latency:** the push occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start-bit falling edge on the pin, ±1 for synchroniser phase. `rd_valid_o` rises on the following edge.
  - At CLKS_PER_BIT=16 this is 154±1 cycles, with `rd_valid_o` high at 155±1.
- **Back-to-back frames:** with no idle gap, IDLE detects the next start bit in the cycle after STOP returns. The drift is < ½ bit over the frame.
- **Pop latency:** after a pop, `rd_valid_o` and `rd_data_o` update on the next edge.
- **Flags and flow control:** `cts_n_o`, `frame_err_o` and `overrun_o` change one cycle after the causing push, pop or stop sample.

## Test plan
All scenarios use the defaults (CLKS_PER_BIT=16, FIFO_DEPTH=4, CTS_MARGIN=1).
- **Single byte:** after reset, send 0xA5 as 8N1 at 16 clk/bit with `rd_ready_i`=0 → `rd_valid_o` rises 155±1 cycles after the start edge; `rd_data_o`=0xA5; no flags set; `cts_n_o`=0. Then pulse `rd_ready_i` for 1 cycle → `rd_valid_o`=0.
- **Glitch rejection:** hold the line low for 5 cycles, then high → no push, `rd_valid_o` stays 0, FSM back in IDLE. A following 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit driven 0, and keep the line low for 40 cycles → `frame_err_o`=1, no push, no new frame decoded until the line returns high. Then send 0x12 → it is received. Pulse `clr_err_i` → `frame_err_o`=0.
- **Fill, flow control and overrun:** send back-to-back 0x01, 0x02, 0x03, 0x04, 0x05 with `rd_ready_i`=0.
  - `cts_n_o` goes to 1 one cycle after the push of 0x03.
  - 0x05 sets `overrun_o`.
  - Four pops then return 0x01–0x04 in order, and `cts_n_o` returns to 0 after the second pop.
- **Push with pop at full:** with the FIFO holding 4 bytes, assert `rd_ready_i` in exactly the push cycle of 0x66 → no overrun, count stays 4, 0x66 is read last.
- **Reset mid-frame:** assert `rst_n_i`=0 for 1 cycle during data bit 4 of a frame, with the line released high → all outputs at reset values, FIFO empty, and the next 0x81 is received correctly.

Source files
------------

// File: rtl/alpacacorn_uart_rx.sv
// alpacacorn_uart_rx: RS232 8N1 receive front end.
// Synchronises the RX pad, deserialises frames mid-bit, buffers bytes in a
// small FIFO drained through a valid/ready port, drives CTS from the fill
// level and keeps sticky framing / overrun flags.
module alpacacorn_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CTS_MARGIN   = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rs232_rx_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       cts_n_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_err_i
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  // Fill level at which the free space has dropped to CTS_MARGIN entries.
  localparam logic [PTR_W:0]   CTS_LVL   = (PTR_W + 1)'(FIFO_DEPTH - CTS_MARGIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchroniser stages; rx_s is the clean, clock-domain copy of the pad.
  logic rx_p0;
  logic rx_p1;
  logic rx_s;

  // Deserialiser state.
  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_sr;
  logic             tick;

  // Completed byte handed from the deserialiser to the FIFO.
  logic [7:0] byte_p2;
  logic       vld_p2;

  // FIFO.
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             overflow;

  assign rx_s = rx_p1;
  assign tick = (bit_cnt == '0);

  // Two-flop synchroniser on the asynchronous pad, idling high out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rs232_rx_i;
      rx_p1 <= rx_p0;
    end
  end

  // Frame FSM: bit timing, stop-bit check, byte-complete strobe, framing flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      vld_p2      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      vld_p2  <= 1'b0;
      bit_cnt <= bit_cnt - 1'b1;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            bit_cnt <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              // Line went high again by mid start bit: a glitch, not a frame.
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            bit_cnt <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              vld_p2 <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              // Low stop bit: drop the byte and wait out the break.
              state <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A set in the same cycle as a clear wins.
      if (state == ST_STOP && tick && !rx_s) begin
        frame_err_o <= 1'b1;
      end else if (clr_err_i) begin
        frame_err_o <= 1'b0;
      end
    end
  end

  // Data bits shift in LSB-first at each mid-bit sample; byte latched on stop.
  always_ff @(posedge clk_i) begin
    if (state == ST_DATA && tick) begin
      shift_sr <= {rx_s, shift_sr[7:1]};
    end
    if (state == ST_STOP && tick) begin
      byte_p2 <= shift_sr;
    end
  end

  assign full     = (count == FULL_CNT);
  assign pop      = rd_valid_o & rd_ready_i;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok  = vld_p2 & (~full | pop);
  assign overflow = vld_p2 & full & ~pop;

  // Next fill level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push_ok && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // FIFO pointers, fill level, flow control and the overrun flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cts_n_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      cts_n_o <= (count_nxt >= CTS_LVL);
      if (overflow) begin
        overrun_o <= 1'b1;
      end else if (clr_err_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

  // FIFO storage; a dropped byte never touches existing entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= byte_p2;
    end
  end

  assign rd_valid_o = (count != '0);
  // Storage is not reset, so the head is masked to zero while empty.
  assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_alpacacorn_uart_rx.sv
// Testbench for alpacacorn_uart_rx: directed frames against a queue-based
// reference model plus literal expectations for each scenario.
module tb_alpacacorn_uart_rx;

  localparam int CPB    = 16;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;
  // Edges from the first edge that sees the start bit on the pin to the edge
  // after which rd_valid_o shows the byte: 2 sync + CPB/2 + 9*CPB + 1.
  localparam int PUSH_AT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_ready;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       cts_n;
  logic       frame_err;
  logic       overrun;

  alpacacorn_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CTS_MARGIN  (MARGIN)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rs232_rx_i (rx),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .cts_n_o    (cts_n),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .clr_err_i  (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         is_fe;
    logic [7:0] data;
  } evt_t;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         rise_cyc = -1;
  int         last_t0 = 0;
  bit         chk_en = 1'b0;
  evt_t       evq[$];
  logic [7:0] mq[$];
  bit         m_fe = 1'b0;
  bit         m_ov = 1'b0;
  bit         m_cts = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Reference model: each edge applies the consumer pop, then any byte or
  // framing event whose time has come, using FIFO rules on a plain queue.
  initial begin
    forever begin
      bit         pop;
      bit         push;
      bit         fe_set;
      bit         ov_set;
      logic [7:0] pd;
      @(posedge clk);
      cyc++;
      pop    = (mq.size() != 0) && rd_ready;
      push   = 1'b0;
      fe_set = 1'b0;
      pd     = 8'h00;
      if (evq.size() != 0 && evq[0].due == cyc) begin
        if (evq[0].is_fe) fe_set = 1'b1;
        else begin
          push = 1'b1;
          pd   = evq[0].data;
        end
        void'(evq.pop_front());
      end
      if (!rst_n) begin
        mq.delete();
        evq.delete();
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        m_cts = 1'b0;
      end else begin
        ov_set = push && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !ov_set) mq.push_back(pd);
        if (fe_set) m_fe = 1'b1;
        else if (clr_err) m_fe = 1'b0;
        if (ov_set) m_ov = 1'b1;
        else if (clr_err) m_ov = 1'b0;
        m_cts = ((DEPTH - mq.size()) <= MARGIN);
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rd_valid", rd_valid, mq.size() != 0);
        if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
        check("cts_n", cts_n, m_cts);
        check("frame_err", frame_err, m_fe);
        check("overrun", overrun, m_ov);
        if (rise_cyc < 0 && rd_valid) rise_cyc = cyc;
      end
    end
  end

  // Drives one 8N1 frame starting at the current falling edge and schedules
  // its expected effect on the model.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    evt_t e;
    e.data  = b;
    e.is_fe = !stop_ok;
    e.due   = cyc + 1 + PUSH_AT - (stop_ok ? 0 : 1);
    evq.push_back(e);
    last_t0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, rd_data, exp);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  logic [7:0] ppf_exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rd_ready = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 8'h00);
    check("rst_cts", cts_n, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    repeat (5) @(negedge clk);

    // Single byte.
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    check_rng("a5_latency", rise_cyc - last_t0 - 1, 154, 156);
    check("a5_data", rd_data, 8'hA5);
    check("a5_fe", frame_err, 1'b0);
    check("a5_ovr", overrun, 1'b0);
    check("a5_cts", cts_n, 1'b0);
    pop_expect("a5_pop", 8'hA5);
    check("a5_empty", rd_valid, 1'b0);

    // Glitch rejection.
    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_novalid", rd_valid, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    pop_expect("glitch_next", 8'h3C);

    // Framing error with a long break.
    repeat (10) @(negedge clk);
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("fe_set", frame_err, 1'b1);
    check("fe_nopush", rd_valid, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h12, 1'b1);
    check("fe_next_data", rd_data, 8'h12);
    check("fe_still", frame_err, 1'b1);
    pulse_clr();
    check("fe_cleared", frame_err, 1'b0);
    pop_expect("fe_pop", 8'h12);

    // Fill, flow control and overrun.
    repeat (10) @(negedge clk);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    check("cts_two", cts_n, 1'b0);
    send_frame(8'h03, 1'b1);
    check("cts_three", cts_n, 1'b1);
    send_frame(8'h04, 1'b1);
    send_frame(8'h05, 1'b1);
    check("ovr_set", overrun, 1'b1);
    pop_expect("fill_pop1", 8'h01);
    check("cts_after_pop1", cts_n, 1'b1);
    pop_expect("fill_pop2", 8'h02);
    check("cts_after_pop2", cts_n, 1'b0);
    pop_expect("fill_pop3", 8'h03);
    pop_expect("fill_pop4", 8'h04);
    check("fill_empty", rd_valid, 1'b0);

    // Push with pop at full.
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    fork
      send_frame(8'h66, 1'b1);
      begin
        repeat (PUSH_AT) @(negedge clk);
        check("ppf_head", rd_data, 8'h11);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    check("ppf_no_ovr", overrun, 1'b0);
    check("ppf_cts", cts_n, 1'b1);
    for (int i = 0; i < 4; i++) pop_expect("ppf_pop", ppf_exp[i]);
    check("ppf_empty", rd_valid, 1'b0);

    // Reset mid-frame with flags set and a byte buffered.
    repeat (10) @(negedge clk);
    send_frame(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h77, 1'b1);
    check("pre_rst_valid", rd_valid, 1'b1);
    check("pre_rst_fe", frame_err, 1'b1);
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", rd_valid, 1'b0);
    check("mid_rst_data", rd_data, 8'h00);
    check("mid_rst_cts", cts_n, 1'b0);
    check("mid_rst_fe", frame_err, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    repeat (200) @(negedge clk);
    check("mid_rst_idle", rd_valid, 1'b0);
    send_frame(8'h81, 1'b1);
    pop_expect("mid_rst_next", 8'h81);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
